// File: rtl/corevx_ptw_multilevel_if.sv
// ArmleoBus master-side connection used by the CoreVX page-table walker.
// Address and data widths follow the walker's PPN/VPN parameters.
interface corevx_ptw_multilevel_if #(
    parameter int ADDR_W = 34,
    parameter int DATA_W = 32
);
    logic              m_transaction;
    logic [2:0]        m_cmd;
    logic [ADDR_W-1:0] m_address;
    logic [2:0]        m_transaction_response;
    logic              m_transaction_done;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output m_transaction,
        output m_cmd,
        output m_address,
        input  m_transaction_response,
        input  m_transaction_done,
        input  m_rdata
    );

    modport slave (
        input  m_transaction,
        input  m_cmd,
        input  m_address,
        output m_transaction_response,
        output m_transaction_done,
        output m_rdata
    );
endinterface

// File: rtl/corevx_ptw_multilevel.sv
// Multi-level page-table walker: resolves a VPN to a PPN with one PTE read per level,
// supporting bare mode, Accessed-bit checking and abort of an in-flight walk.
module corevx_ptw_multilevel #(
    parameter int LEVELS  = 2,
    parameter int VPN_W   = 10,
    parameter int PPN_W   = 22,
    parameter int CHECK_A = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    corevx_ptw_multilevel_if.master                      bus,
    input  logic                                         resolve_request,
    output logic                                         resolve_ack,
    input  logic [LEVELS*VPN_W-1:0]                      virtual_address,
    input  logic                                         resolve_abort,
    output logic                                         resolve_done,
    output logic                                         resolve_pagefault,
    output logic                                         resolve_accessfault,
    output logic [7:0]                                   resolve_access_bits,
    output logic [PPN_W-1:0]                             resolve_physical_address,
    output logic [((LEVELS > 1) ? $clog2(LEVELS) : 1)-1:0] resolve_level,
    input  logic                                         matp_mode,
    input  logic [PPN_W-1:0]                             matp_ppn
);

    localparam int VA_W  = LEVELS * VPN_W;
    localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam logic [LVL_W-1:0] ROOT_LEVEL   = LVL_W'(LEVELS - 1);
    localparam logic [2:0]       CMD_READ     = 3'd1;
    localparam logic [2:0]       RESP_SUCCESS = 3'd0;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t             state_q, state_d;
    logic [VA_W-1:0]    vpn_q;
    logic [PPN_W-1:0]   table_base_q;
    logic [LVL_W-1:0]   level_q;
    logic               abort_pending_q;

    logic               capture, descend, finish;
    logic               res_pf_d, res_af_d;
    logic [7:0]         res_bits_d;
    logic [PPN_W-1:0]   res_pa_d;
    logic [LVL_W-1:0]   res_level_d;

    logic [PPN_W-1:0]   pte_ppn;
    logic [7:0]         pte_flags;
    logic               pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
    logic [1:0]         unused_pte_rsw;
    logic [VPN_W-1:0]   vpn_cur;
    logic [PPN_W-1:0]   lvl_mask, vpn_ext, va_in_ext;
    logic [VA_W+PPN_W-1:0] vpn_wide, va_in_wide;
    logic               abort_hit;

    assign pte_ppn        = bus.m_rdata[PPN_W+9:10];
    assign unused_pte_rsw = bus.m_rdata[9:8];
    assign pte_flags      = bus.m_rdata[7:0];
    assign pte_v          = pte_flags[0];
    assign pte_r          = pte_flags[1];
    assign pte_w          = pte_flags[2];
    assign pte_x          = pte_flags[3];
    assign pte_u          = pte_flags[4];
    assign pte_a          = pte_flags[6];
    assign pte_d          = pte_flags[7];

    assign vpn_cur    = vpn_q[int'(level_q)*VPN_W +: VPN_W];
    // Low bits of a PPN that a leaf at the current level must leave to the VA.
    assign lvl_mask   = (PPN_W'(1) << (int'(level_q) * VPN_W)) - PPN_W'(1);
    assign vpn_wide   = {{PPN_W{1'b0}}, vpn_q};
    assign va_in_wide = {{PPN_W{1'b0}}, virtual_address};
    assign vpn_ext    = vpn_wide[PPN_W-1:0];
    assign va_in_ext  = va_in_wide[PPN_W-1:0];
    assign abort_hit  = abort_pending_q | resolve_abort;

    assign bus.m_transaction = (state_q == WALK);
    assign bus.m_cmd         = CMD_READ;
    assign bus.m_address     = {table_base_q, vpn_cur, 2'b00};
    assign resolve_ack       = (state_q == IDLE) && !resolve_abort;
    assign resolve_done      = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        capture     = 1'b0;
        descend     = 1'b0;
        finish      = 1'b0;
        res_pf_d    = 1'b0;
        res_af_d    = 1'b0;
        res_bits_d  = 8'h00;
        res_pa_d    = '0;
        res_level_d = level_q;
        case (state_q)
            IDLE: begin
                if (resolve_request && !resolve_abort) begin
                    capture = 1'b1;
                    if (matp_mode) begin
                        state_d = WALK;
                    end else begin
                        state_d     = DONE;
                        finish      = 1'b1;
                        res_pa_d    = va_in_ext;
                        res_bits_d  = 8'hCF;
                        res_level_d = '0;
                    end
                end
            end
            WALK: begin
                // An aborted walk still waits for its read so the bus handshake completes.
                if (bus.m_transaction_done) begin
                    if (abort_hit) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DONE;
                        finish     = 1'b1;
                        res_bits_d = pte_flags;
                        if (bus.m_transaction_response != RESP_SUCCESS) begin
                            res_af_d   = 1'b1;
                            res_bits_d = 8'h00;
                        end else if (!pte_v || (pte_w && !pte_r)) begin
                            res_pf_d = 1'b1;
                        end else if (pte_r || pte_x) begin
                            if ((level_q != '0) && ((pte_ppn & lvl_mask) != '0)) begin
                                res_pf_d = 1'b1;
                            end else if ((CHECK_A != 0) && !pte_a) begin
                                res_pf_d = 1'b1;
                            end else begin
                                res_pa_d = (pte_ppn & ~lvl_mask) | (vpn_ext & lvl_mask);
                            end
                        end else if ((level_q == '0) || pte_u || pte_a || pte_d) begin
                            res_pf_d = 1'b1;
                        end else begin
                            state_d = WALK;
                            finish  = 1'b0;
                            descend = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vpn_q                    <= '0;
            table_base_q             <= '0;
            level_q                  <= '0;
            abort_pending_q          <= 1'b0;
            resolve_pagefault        <= 1'b0;
            resolve_accessfault      <= 1'b0;
            resolve_access_bits      <= 8'h00;
            resolve_physical_address <= '0;
            resolve_level            <= '0;
        end else begin
            abort_pending_q <= (state_q == WALK) && (state_d == WALK) && abort_hit;
            if (capture) begin
                vpn_q        <= virtual_address;
                table_base_q <= matp_ppn;
                level_q      <= ROOT_LEVEL;
            end else if (descend) begin
                table_base_q <= pte_ppn;
                level_q      <= level_q - LVL_W'(1);
            end
            if (finish) begin
                resolve_pagefault        <= res_pf_d;
                resolve_accessfault      <= res_af_d;
                resolve_access_bits      <= res_bits_d;
                resolve_physical_address <= res_pa_d;
                resolve_level            <= res_level_d;
            end
        end
    end

endmodule

// File: tb/tb_corevx_ptw_multilevel.sv
// Directed bench for the page-table walker: a 2-level and a 3-level instance,
// bus reads served by hand with precomputed PTEs, addresses and results.
module tb_corevx_ptw_multilevel;

    localparam logic [2:0] CMD_READ = 3'd1;
    localparam logic [2:0] RESP_OK  = 3'd0;
    localparam logic [2:0] RESP_ERR = 3'd2;

    logic clk;
    logic rst;
    int   vectors = 0;
    int   misses  = 0;

    logic        req2, abort2, mode2, ack2, done2, pf2, af2;
    logic [19:0] va2;
    logic [21:0] ppn2, pa2;
    logic [7:0]  bits2;
    logic [0:0]  lvl2;

    logic        req3, abort3, mode3, ack3, done3, pf3, af3;
    logic [29:0] va3, ppn3, pa3;
    logic [7:0]  bits3;
    logic [1:0]  lvl3;

    corevx_ptw_multilevel_if #(.ADDR_W(34), .DATA_W(32)) bus2 ();
    corevx_ptw_multilevel_if #(.ADDR_W(42), .DATA_W(40)) bus3 ();

    corevx_ptw_multilevel #(.LEVELS(2), .VPN_W(10), .PPN_W(22), .CHECK_A(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.master),
        .resolve_request(req2), .resolve_ack(ack2), .virtual_address(va2),
        .resolve_abort(abort2), .resolve_done(done2), .resolve_pagefault(pf2),
        .resolve_accessfault(af2), .resolve_access_bits(bits2),
        .resolve_physical_address(pa2), .resolve_level(lvl2),
        .matp_mode(mode2), .matp_ppn(ppn2)
    );

    corevx_ptw_multilevel #(.LEVELS(3), .VPN_W(10), .PPN_W(30), .CHECK_A(1)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3.master),
        .resolve_request(req3), .resolve_ack(ack3), .virtual_address(va3),
        .resolve_abort(abort3), .resolve_done(done3), .resolve_pagefault(pf3),
        .resolve_accessfault(af3), .resolve_access_bits(bits3),
        .resolve_physical_address(pa3), .resolve_level(lvl3),
        .matp_mode(mode3), .matp_ppn(ppn3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        if (observed !== expected) begin
            misses++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic sampleBus(input bit on_three, output logic txn, output logic [63:0] addr, output logic [2:0] cmd);
        if (on_three) begin
            txn  = bus3.m_transaction;
            addr = 64'(bus3.m_address);
            cmd  = bus3.m_cmd;
        end else begin
            txn  = bus2.m_transaction;
            addr = 64'(bus2.m_address);
            cmd  = bus2.m_cmd;
        end
    endtask

    // Starts a walk at a falling edge; the accepting rising edge follows.
    task automatic applyStimulus(input string tag, input bit on_three, input logic [29:0] va,
                                 input logic mode, input logic [29:0] ppn);
        if (on_three) begin
            req3 = 1'b1; va3 = va; mode3 = mode; ppn3 = ppn;
        end else begin
            req2 = 1'b1; va2 = va[19:0]; mode2 = mode; ppn2 = ppn[21:0];
        end
        #1;
        checkOutput({tag, " ack"}, 64'(on_three ? ack3 : ack2), 64'd1);
        @(negedge clk);
        req2 = 1'b0;
        req3 = 1'b0;
    endtask

    task automatic serveRead(input string tag, input bit on_three, input logic [63:0] exp_addr,
                             input logic [63:0] pte, input logic [2:0] resp, input int wait_cycles);
        logic        txn;
        logic [63:0] addr;
        logic [2:0]  cmd;
        int          n = 0;
        sampleBus(on_three, txn, addr, cmd);
        while (!txn && n < 8) begin
            @(negedge clk);
            n++;
            sampleBus(on_three, txn, addr, cmd);
        end
        checkOutput({tag, " req"}, 64'(txn), 64'd1);
        checkOutput({tag, " addr"}, addr, exp_addr);
        checkOutput({tag, " cmd"}, 64'(cmd), 64'(CMD_READ));
        for (int i = 0; i < wait_cycles; i++) begin
            @(negedge clk);
            sampleBus(on_three, txn, addr, cmd);
            checkOutput({tag, " hold"}, 64'(txn), 64'd1);
        end
        if (on_three) begin
            bus3.m_transaction_done = 1'b1; bus3.m_rdata = pte[39:0]; bus3.m_transaction_response = resp;
        end else begin
            bus2.m_transaction_done = 1'b1; bus2.m_rdata = pte[31:0]; bus2.m_transaction_response = resp;
        end
        @(negedge clk);
        bus2.m_transaction_done = 1'b0; bus2.m_rdata = '0; bus2.m_transaction_response = RESP_OK;
        bus3.m_transaction_done = 1'b0; bus3.m_rdata = '0; bus3.m_transaction_response = RESP_OK;
    endtask

    task automatic waitDone(input string tag, input bit on_three);
        int n = 0;
        while (!(on_three ? done3 : done2) && n < 10) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " done"}, 64'(on_three ? done3 : done2), 64'd1);
        checkOutput({tag, " idle bus"}, 64'(on_three ? bus3.m_transaction : bus2.m_transaction), 64'd0);
    endtask

    task automatic checkResult(input string tag, input bit on_three, input logic [63:0] pa,
                               input logic [7:0] bits, input logic [1:0] lvl, input logic pf, input logic af);
        checkOutput({tag, " pf"}, 64'(on_three ? pf3 : pf2), 64'(pf));
        checkOutput({tag, " af"}, 64'(on_three ? af3 : af2), 64'(af));
        checkOutput({tag, " bits"}, 64'(on_three ? bits3 : bits2), 64'(bits));
        checkOutput({tag, " level"}, on_three ? 64'(lvl3) : 64'(lvl2), 64'(lvl));
        if (!pf && !af) begin
            checkOutput({tag, " pa"}, on_three ? 64'(pa3) : 64'(pa2), pa);
        end
    endtask

    // Done must last one cycle and the walker must return to accepting requests.
    task automatic settle(input string tag, input bit on_three);
        @(negedge clk);
        checkOutput({tag, " done pulse"}, 64'(on_three ? done3 : done2), 64'd0);
        checkOutput({tag, " ack after"}, 64'(on_three ? ack3 : ack2), 64'd1);
    endtask

    initial begin
        rst = 1'b1;
        req2 = 0; abort2 = 0; mode2 = 0; va2 = '0; ppn2 = '0;
        req3 = 0; abort3 = 0; mode3 = 0; va3 = '0; ppn3 = '0;
        bus2.m_transaction_done = 0; bus2.m_rdata = '0; bus2.m_transaction_response = RESP_OK;
        bus3.m_transaction_done = 0; bus3.m_rdata = '0; bus3.m_transaction_response = RESP_OK;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset ack", 64'(ack2), 64'd1);
        checkOutput("reset done", 64'(done2), 64'd0);
        checkOutput("reset txn", 64'(bus2.m_transaction), 64'd0);
        checkOutput("reset pa", 64'(pa2), 64'd0);
        checkOutput("reset bits", 64'(bits2), 64'd0);
        checkOutput("reset flags", 64'({pf2, af2, lvl2}), 64'd0);
        checkOutput("reset3 txn", 64'(bus3.m_transaction), 64'd0);
        @(negedge clk);

        // Two-level translation through a pointer, leaf read with wait states.
        applyStimulus("t1", 0, {10'h012, 10'h345}, 1'b1, 30'h00ABC);
        serveRead("t1 root", 0, {22'h00ABC, 10'h012, 2'b00}, {22'h00123, 2'b00, 8'h01}, RESP_OK, 0);
        serveRead("t1 leaf", 0, {22'h00123, 10'h345, 2'b00}, {22'h2ABCD, 2'b00, 8'h4F}, RESP_OK, 2);
        waitDone("t1", 0);
        checkResult("t1", 0, 22'h2ABCD, 8'h4F, 2'd0, 1'b0, 1'b0);
        settle("t1", 0);

        applyStimulus("t2", 0, {10'h001, 10'h155}, 1'b1, 30'h00ABC);
        serveRead("t2 root", 0, {22'h00ABC, 10'h001, 2'b00}, {22'h00400, 2'b00, 8'h4B}, RESP_OK, 0);
        waitDone("t2", 0);
        checkResult("t2", 0, 22'h00555, 8'h4B, 2'd1, 1'b0, 1'b0);
        settle("t2", 0);

        applyStimulus("t3", 0, {10'h001, 10'h155}, 1'b1, 30'h00ABC);
        serveRead("t3 root", 0, {22'h00ABC, 10'h001, 2'b00}, {22'h00401, 2'b00, 8'h4B}, RESP_OK, 0);
        waitDone("t3", 0);
        checkResult("t3", 0, 22'h0, 8'h4B, 2'd1, 1'b1, 1'b0);
        settle("t3", 0);

        applyStimulus("t4", 0, {10'h012, 10'h345}, 1'b1, 30'h00ABC);
        serveRead("t4 root", 0, {22'h00ABC, 10'h012, 2'b00}, {22'h00123, 2'b00, 8'h01}, RESP_ERR, 0);
        waitDone("t4", 0);
        checkResult("t4", 0, 22'h0, 8'h00, 2'd1, 1'b0, 1'b1);
        settle("t4", 0);

        applyStimulus("t5", 0, {10'h012, 10'h345}, 1'b1, 30'h00ABC);
        serveRead("t5 root", 0, {22'h00ABC, 10'h012, 2'b00}, {22'h00123, 2'b00, 8'h01}, RESP_OK, 0);
        serveRead("t5 leaf", 0, {22'h00123, 10'h345, 2'b00}, {22'h2ABCD, 2'b00, 8'h0B}, RESP_OK, 0);
        waitDone("t5", 0);
        checkResult("t5", 0, 22'h0, 8'h0B, 2'd0, 1'b1, 1'b0);
        settle("t5", 0);

        applyStimulus("t6", 0, {10'h001, 10'h155}, 1'b1, 30'h00ABC);
        serveRead("t6 root", 0, {22'h00ABC, 10'h001, 2'b00}, {22'h00400, 2'b00, 8'h45}, RESP_OK, 0);
        waitDone("t6", 0);
        checkResult("t6", 0, 22'h0, 8'h45, 2'd1, 1'b1, 1'b0);
        settle("t6", 0);

        applyStimulus("t7", 0, {10'h012, 10'h345}, 1'b1, 30'h00ABC);
        serveRead("t7 root", 0, {22'h00ABC, 10'h012, 2'b00}, {22'h00123, 2'b00, 8'h41}, RESP_OK, 0);
        waitDone("t7", 0);
        checkResult("t7", 0, 22'h0, 8'h41, 2'd1, 1'b1, 1'b0);
        settle("t7", 0);

        applyStimulus("t8", 0, {10'h012, 10'h345}, 1'b1, 30'h00ABC);
        serveRead("t8 root", 0, {22'h00ABC, 10'h012, 2'b00}, {22'h00123, 2'b00, 8'h01}, RESP_OK, 0);
        serveRead("t8 leaf", 0, {22'h00123, 10'h345, 2'b00}, {22'h00321, 2'b00, 8'h01}, RESP_OK, 0);
        waitDone("t8", 0);
        checkResult("t8", 0, 22'h0, 8'h01, 2'd0, 1'b1, 1'b0);
        settle("t8", 0);

        // Abort while the root read is outstanding; the read completes 3 cycles later.
        applyStimulus("t9", 0, {10'h012, 10'h345}, 1'b1, 30'h00ABC);
        abort2 = 1'b1;
        #1;
        checkOutput("t9 ack during abort", 64'(ack2), 64'd0);
        @(negedge clk);
        abort2 = 1'b0;
        serveRead("t9 root", 0, {22'h00ABC, 10'h012, 2'b00}, {22'h00123, 2'b00, 8'h01}, RESP_OK, 2);
        checkOutput("t9 no next read", 64'(bus2.m_transaction), 64'd0);
        checkOutput("t9 ack", 64'(ack2), 64'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t9 no done", 64'(done2), 64'd0);
            @(negedge clk);
        end
        checkOutput("t9 held bits", 64'(bits2), 64'h01);

        // Abort wins over a same-cycle request.
        req2 = 1'b1; abort2 = 1'b1; mode2 = 1'b1;
        #1;
        checkOutput("t10 ack", 64'(ack2), 64'd0);
        @(negedge clk);
        req2 = 1'b0; abort2 = 1'b0;
        #1;
        checkOutput("t10 no walk", 64'(bus2.m_transaction), 64'd0);
        checkOutput("t10 no done", 64'(done2), 64'd0);
        @(negedge clk);

        // Bare mode answers one cycle after accept without touching the bus.
        applyStimulus("t11", 0, 30'h00FFFFF, 1'b0, 30'h00ABC);
        checkOutput("t11 done", 64'(done2), 64'd1);
        checkOutput("t11 txn", 64'(bus2.m_transaction), 64'd0);
        checkResult("t11", 0, 22'h0FFFFF, 8'hCF, 2'd0, 1'b0, 1'b0);
        settle("t11", 0);

        applyStimulus("t12", 1, {10'h3FF, 10'h2AA, 10'h155}, 1'b1, 30'h0001234);
        serveRead("t12 l2", 1, {30'h0001234, 10'h3FF, 2'b00}, {30'h0000567, 2'b00, 8'h01}, RESP_OK, 0);
        serveRead("t12 l1", 1, {30'h0000567, 10'h2AA, 2'b00}, {30'h000089A, 2'b00, 8'h01}, RESP_OK, 1);
        serveRead("t12 l0", 1, {30'h000089A, 10'h155, 2'b00}, {30'h0ABCDEF, 2'b00, 8'hCF}, RESP_OK, 0);
        waitDone("t12", 1);
        checkResult("t12", 1, 30'h0ABCDEF, 8'hCF, 2'd0, 1'b0, 1'b0);
        settle("t12", 1);

        // Reset with the level-1 read outstanding.
        applyStimulus("t13", 1, {10'h3FF, 10'h2AA, 10'h155}, 1'b1, 30'h0001234);
        serveRead("t13 l2", 1, {30'h0001234, 10'h3FF, 2'b00}, {30'h0000567, 2'b00, 8'h01}, RESP_OK, 0);
        checkOutput("t13 l1 pending", 64'(bus3.m_transaction), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("t13 txn", 64'(bus3.m_transaction), 64'd0);
        checkOutput("t13 done", 64'(done3), 64'd0);
        checkOutput("t13 ack", 64'(ack3), 64'd1);
        checkOutput("t13 pa", 64'(pa3), 64'd0);
        checkOutput("t13 bits", 64'(bits3), 64'd0);
        checkOutput("t13 flags", 64'({pf3, af3, lvl3}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
